val2_shifter_pipe: RTL
======================

VAL2_SHIFTER_PIPE -- requirements
Module: val2_shifter_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; power of two, 16..64.
REQ-002 clk  input  1  rising-edge clock; rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
REQ-003 in_valid  input  1  request valid; in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-004 imm  input  1  immediate form; mem_en  input  1  load/store offset form (priority over imm); reg_shift  input  1  shift amount from rs_val.
REQ-005 shifter_operand  input  12  instruction operand field; rm_val  input  DATA_W  Rm value; rs_val  input  8  Rs[7:0].
REQ-006 carry_in  input  1  current C flag; flush  input  1  discard all in-flight requests.
REQ-007 out_valid  output  1  result valid; out_ready  input  1  consumer accepts; val2  output  DATA_W  operand; carry_out  output  1  shifter carry.

Function
REQ-008 Two-stage pipeline: S1 registers decoded kind/type/amount/operands; S2 registers val2 and carry_out; latency 2 cycles, throughput 1/cycle with out_ready high.
REQ-009 in_ready = rst_n && !flush && (!s1_valid || S1 advances); S1 advances when !s2_valid || out_ready.
REQ-010 out_valid, val2, carry_out hold stable while out_valid && !out_ready; no request is dropped or duplicated under backpressure.
REQ-011 mem_en: val2 = shifter_operand sign-extended to DATA_W; carry_out = carry_in.
REQ-012 imm: val2 = zero-extended operand[7:0] rotated right by 2*operand[11:8]; carry_out = carry_in if rotate is 0, else val2[DATA_W-1].
REQ-013 Register form: type = operand[6:5] (LSL/LSR/ASR/ROR); amount = operand[11:7] when !reg_shift, rs_val when reg_shift.
REQ-014 Immediate amount 0: LSL -> rm, carry_in; LSR -> 0, rm[MSB]; ASR -> all rm[MSB], carry rm[MSB]; ROR -> RRX {carry_in, rm[MSB:1]}, carry rm[0].
REQ-015 Register amount 0: val2 = rm_val, carry_out = carry_in, all types.
REQ-016 Amount n, 0<n<DATA_W: standard shift; carry = last bit shifted out.
REQ-017 n == DATA_W: LSL -> 0, carry rm[0]; LSR -> 0, carry rm[MSB]; n > DATA_W: LSL/LSR -> 0, carry 0; ASR n >= DATA_W -> sign fill, carry rm[MSB].
REQ-018 ROR n>0: rotate by n mod DATA_W; if n mod DATA_W == 0, val2 = rm_val, carry rm[MSB].
REQ-019 flush: S1 and S2 valid cleared next edge; request presented in flush cycle not accepted; flush overrides out_ready.

Reset
REQ-020 rst_n low: s1_valid=0, out_valid=0, val2=0, carry_out=0, in_ready=0 immediately; mid-operation requests discarded.
REQ-021 First edge after rst_n rises may accept a request.

Configuration
REQ-022 Macro VAL2_SHIFTER_CARRY_EN defined: carry_out per REQ-011..018.
REQ-023 Macro undefined: carry_out = registered carry_in of the same request; val2 unchanged; carry logic removed.

Structure
REQ-024 Package val2_pkg: shift_t enum (LSL=0, LSR=1, ASR=2, ROR=3), op-kind enum (MEM, IMM, REG), DATA_W default constant.
REQ-025 Sub-module val2_barrel: combinational log-depth shifter (value, type, amount, carry_in -> result, carry), instantiated in S2.

Verification
REQ-026 imm=1, operand=0x4FF -> val2=0xFF000000, carry_out=1, out_valid exactly 2 cycles after acceptance.
REQ-027 mem_en=1, operand=0x804 -> val2=0xFFFFF804, carry_out=carry_in.
REQ-028 Reg ROR #0, rm=0x00000003, carry_in=1 -> val2=0x80000001, carry_out=1; LSR #0, rm=0x80000000 -> val2=0, carry_out=1.
REQ-029 reg_shift, LSL, rs=32, rm=0x1 -> 0, carry 1; rs=33 -> 0, carry 0; ASR rs=200, rm=0x80000000 -> 0xFFFFFFFF, carry 1.
REQ-030 Back-to-back 8 requests, out_ready low 3 cycles mid-stream -> all 8 results in order, none lost, in_ready low while full.
REQ-031 flush with two in flight, and rst_n low mid-stream -> out_valid 0 next cycle/immediately, no stale result later.

Source files
------------

// File: rtl/val2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : val2_pkg
// Brief    : Shared types for the val2 shifter pipeline
//            (optional shifter carry: VAL2_SHIFTER_CARRY_EN)
// Revision : 1.0
// ============================================================================
package val2_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROR = 2'd3
  } shift_t;

  typedef enum logic [1:0] {
    OP_MEM = 2'd0,
    OP_IMM = 2'd1,
    OP_REG = 2'd2
  } op_kind_t;

  // Decoded request held in S1 alongside the operand value
  typedef struct packed {
    op_kind_t   kind;
    shift_t     sh;
    logic       rrx;
    logic [7:0] amt;
    logic       carry;
  } s1_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/val2_barrel.sv
`default_nettype none
// ============================================================================
// Module   : val2_barrel
// Brief    : Combinational log-depth shifter with carry-out
// Revision : 1.0
// ============================================================================
module val2_barrel
  import val2_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter bit CARRY_EN = 1'b1
) (
  input  logic [DATA_W-1:0] value_i,
  input  shift_t            sh_i,
  input  logic [7:0]        amt_i,
  input  logic              rrx_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  localparam int         LG     = $clog2(DATA_W) + 1;
  localparam int         RW     = $clog2(DATA_W);
  localparam logic [7:0] C_LSAT = 8'(DATA_W + 1);
  localparam logic [7:0] C_ASAT = 8'(DATA_W);

  logic [LG-1:0]     w_lamt;
  logic [LG-1:0]     w_aamt;
  logic [DATA_W:0]   w_lsl;
  logic [DATA_W:0]   w_lsr;
  logic [DATA_W:0]   w_asr;
  logic [DATA_W-1:0] w_ror;
  logic              w_carry;

  // Saturating one past the width makes every out-of-range shift carry 0
  assign w_lamt = (amt_i > C_LSAT) ? C_LSAT[LG-1:0] : amt_i[LG-1:0];
  assign w_aamt = (amt_i > C_ASAT) ? C_ASAT[LG-1:0] : amt_i[LG-1:0];

  always_comb begin
    w_lsl = {1'b0, value_i};
    w_lsr = {value_i, 1'b0};
    w_asr = {value_i, 1'b0};
    w_ror = value_i;
    for (int k = 0; k < LG; k++) begin
      if (w_lamt[k]) begin
        w_lsl = w_lsl << (1 << k);
        w_lsr = w_lsr >> (1 << k);
      end
      if (w_aamt[k]) w_asr = $signed(w_asr) >>> (1 << k);
    end
    for (int k = 0; k < RW; k++) begin
      if (amt_i[k]) w_ror = (w_ror >> (1 << k)) | (w_ror << (DATA_W - (1 << k)));
    end
  end

  always_comb begin
    result_o = value_i;
    w_carry  = carry_i;
    if (rrx_i) begin
      result_o = {carry_i, value_i[DATA_W-1:1]};
      w_carry  = value_i[0];
    end else if (amt_i != 8'd0) begin
      case (sh_i)
        LSL: begin result_o = w_lsl[DATA_W-1:0]; w_carry = w_lsl[DATA_W]; end
        LSR: begin result_o = w_lsr[DATA_W:1];   w_carry = w_lsr[0];      end
        ASR: begin result_o = w_asr[DATA_W:1];   w_carry = w_asr[0];      end
        ROR: begin result_o = w_ror;             w_carry = w_ror[DATA_W-1]; end
        default: ;
      endcase
    end
  end

  assign carry_o = CARRY_EN ? w_carry : carry_i;

endmodule
`default_nettype wire

// File: rtl/val2_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : val2_shifter_pipe
// Brief    : Two-stage operand-2 shifter; VAL2_SHIFTER_CARRY_EN enables the
//            shifter carry, otherwise carry_out is the request's carry_in
// Revision : 1.0
// ============================================================================
module val2_shifter_pipe
  import val2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic              mem_en,
  input  logic              reg_shift,
  input  logic [11:0]       shifter_operand,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [7:0]        rs_val,
  input  logic              carry_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

`ifdef VAL2_SHIFTER_CARRY_EN
  localparam bit C_CARRY_EN = 1'b1;
`else
  localparam bit C_CARRY_EN = 1'b0;
`endif
  localparam logic [7:0] C_W = 8'(DATA_W);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  s1_ctrl_t          s1_ctrl_q, s1_ctrl_d;
  logic [DATA_W-1:0] s1_value_q, s1_value_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic              carry_q, carry_d;
  logic              w_s1_adv;
  logic              w_accept;
  logic [DATA_W-1:0] w_bar_result;
  logic              w_bar_carry;

  assign w_s1_adv = !s2_valid_q || out_ready;
  assign in_ready = rst_n && !flush && (!s1_valid_q || w_s1_adv);
  assign w_accept = in_valid && in_ready;

  // Immediate-encoded zero shifts are remapped so the barrel sees plain amounts
  always_comb begin
    s1_ctrl_d  = s1_ctrl_q;
    s1_value_d = s1_value_q;
    if (w_accept) begin
      s1_ctrl_d.carry = carry_in;
      s1_ctrl_d.rrx   = 1'b0;
      if (mem_en) begin
        s1_ctrl_d.kind = OP_MEM;
        s1_ctrl_d.sh   = LSL;
        s1_ctrl_d.amt  = 8'd0;
        s1_value_d     = {{(DATA_W-12){shifter_operand[11]}}, shifter_operand};
      end else if (imm) begin
        s1_ctrl_d.kind = OP_IMM;
        s1_ctrl_d.sh   = ROR;
        s1_ctrl_d.amt  = {3'b000, shifter_operand[11:8], 1'b0};
        s1_value_d     = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
      end else begin
        s1_ctrl_d.kind = OP_REG;
        s1_ctrl_d.sh   = shift_t'(shifter_operand[6:5]);
        s1_value_d     = rm_val;
        if (reg_shift) begin
          s1_ctrl_d.amt = rs_val;
        end else if (shifter_operand[11:7] != 5'd0) begin
          s1_ctrl_d.amt = {3'b000, shifter_operand[11:7]};
        end else begin
          s1_ctrl_d.amt = 8'd0;
          case (shift_t'(shifter_operand[6:5]))
            LSR, ASR: s1_ctrl_d.amt = C_W;
            ROR:      s1_ctrl_d.rrx = 1'b1;
            default:  ;
          endcase
        end
      end
    end
  end

  val2_barrel #(
    .DATA_W   (DATA_W),
    .CARRY_EN (C_CARRY_EN)
  ) u_barrel (
    .value_i  (s1_value_q),
    .sh_i     (s1_ctrl_q.sh),
    .amt_i    (s1_ctrl_q.amt),
    .rrx_i    (s1_ctrl_q.rrx),
    .carry_i  (s1_ctrl_q.carry),
    .result_o (w_bar_result),
    .carry_o  (w_bar_carry)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    val2_d     = val2_q;
    carry_d    = carry_q;
    if (!s1_valid_q || w_s1_adv) s1_valid_d = w_accept;
    if (w_s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        val2_d  = (s1_ctrl_q.kind == OP_MEM) ? s1_value_q : w_bar_result;
        carry_d = (s1_ctrl_q.kind == OP_MEM) ? s1_ctrl_q.carry : w_bar_carry;
      end
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_value_q <= '0;
      val2_q     <= '0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_ctrl_q  <= s1_ctrl_d;
      s1_value_q <= s1_value_d;
      val2_q     <= val2_d;
      carry_q    <= carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

endmodule
`default_nettype wire
